// File: rtl/antares_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module      : antares_hilo_unit
// Description : HI/LO register unit for a MIPS-style pipeline. Tracks the
//               operation class of every product in flight in the external
//               4-stage multiplier with a 4-entry tag FIFO. When a product
//               returns, the head tag is used to decide its destination:
//               overwrite HI/LO (MULT), accumulate into HI/LO (MADD),
//               subtract from HI/LO (MSUB) or write back to a GPR (MUL).
//               MTHI/MTLO write HI or LO directly. Protocol violations raise
//               a sticky error flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1   clock, rising edge
//   rst            in   1   asynchronous reset, active low
//   issue_valid    in   1   instruction for this unit presented this cycle
//   issue_op       in   3   0 MULT, 1 MADD, 2 MSUB, 3 MUL, 4 MTHI, 5 MTLO
//   mt_data        in  32   MTHI/MTLO source operand
//   mult_result    in  64   product from the multiplier
//   mult_ready     in   1   mult_result valid
//   stall          in   1   pipeline freeze
//   flush          in   1   discard in-flight operations
//   mult_enable_op out  1   issue strobe to the multiplier
//   hi, lo         out 32   architectural HI/LO registers
//   gpr_result     out 32   MUL writeback data
//   gpr_valid      out  1   MUL writeback strobe (one cycle)
//   hilo_busy      out  1   products in flight
//   err            out  1   sticky protocol-error flag
// ============================================================================
module antares_hilo_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [2:0]  issue_op,
    input  logic [31:0] mt_data,
    input  logic [63:0] mult_result,
    input  logic        mult_ready,
    input  logic        stall,
    input  logic        flush,
    output logic        mult_enable_op,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] gpr_result,
    output logic        gpr_valid,
    output logic        hilo_busy,
    output logic        err
);

    localparam int         FIFO_DEPTH = 4;
    localparam int         PTR_W      = 2;
    localparam int         CNT_W      = 3;

    localparam logic [2:0] OP_MTHI    = 3'd4;
    localparam logic [2:0] OP_MTLO    = 3'd5;

    localparam logic [1:0] TAG_MULT   = 2'd0;
    localparam logic [1:0] TAG_MADD   = 2'd1;
    localparam logic [1:0] TAG_MSUB   = 2'd2;
    localparam logic [1:0] TAG_MUL    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       fifo_q [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      gpr_result_q, gpr_result_d;
    logic             gpr_valid_q, gpr_valid_d;
    logic             err_q, err_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       w_go;
    logic       w_issue;
    logic       w_mult_op;
    logic       w_mt_hi;
    logic       w_mt_lo;
    logic       w_reserved;
    logic       w_pop_req;
    logic       w_empty;
    logic       w_full;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_head_tag;
    logic [63:0] w_hilo;

    // stall and flush both block every state-changing action on this cycle;
    // flush additionally empties the FIFO below.
    assign w_go       = ~stall & ~flush;
    assign w_issue    = issue_valid & w_go;
    assign w_mult_op  = w_issue & ~issue_op[2];
    assign w_mt_hi    = w_issue & (issue_op == OP_MTHI);
    assign w_mt_lo    = w_issue & (issue_op == OP_MTLO);
    assign w_reserved = w_issue & issue_op[2] & issue_op[1];

    assign w_pop_req  = mult_ready & w_go;
    assign w_empty    = (count_q == '0);
    assign w_full     = (count_q == CNT_FULL);

    // The full check uses the count before any same-cycle pop, so an issue
    // that arrives with four products already tracked is always dropped.
    assign w_push     = w_mult_op & ~w_full;
    assign w_pop      = w_pop_req & ~w_empty;
    assign w_head_tag = fifo_q[head_q];
    assign w_hilo     = {hi_q, lo_q};

    assign mult_enable_op = w_mult_op;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        gpr_result_d = gpr_result_q;
        gpr_valid_d  = 1'b0;
        err_d        = err_q;

        // Protocol errors: product with nothing tracked, issue into a full
        // FIFO, HI/LO move while products are in flight, reserved opcode.
        if ((w_pop_req & w_empty) | (w_mult_op & w_full) |
            ((w_mt_hi | w_mt_lo) & ~w_empty) | w_reserved) begin
            err_d = 1'b1;
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (w_pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end

        // Direct moves are applied first so that a same-cycle product
        // targeting HI/LO overrides them.
        if (w_mt_hi) begin
            hi_d = mt_data;
        end
        if (w_mt_lo) begin
            lo_d = mt_data;
        end

        if (w_pop) begin
            case (w_head_tag)
                TAG_MULT: {hi_d, lo_d} = mult_result;
                TAG_MADD: {hi_d, lo_d} = w_hilo + mult_result;
                TAG_MSUB: {hi_d, lo_d} = w_hilo - mult_result;
                TAG_MUL: begin
                    gpr_result_d = mult_result[31:0];
                    gpr_valid_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= TAG_MULT;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            gpr_result_q <= '0;
            gpr_valid_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (w_push) begin
                fifo_q[tail_q] <= issue_op[1:0];
            end
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            gpr_result_q <= gpr_result_d;
            gpr_valid_q  <= gpr_valid_d;
            err_q        <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign gpr_result = gpr_result_q;
    assign gpr_valid  = gpr_valid_q;
    assign hilo_busy  = ~w_empty;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_antares_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_antares_hilo_unit
// Description : Self-checking bench for antares_hilo_unit. A behavioural
//               model (tag queue + 64-bit HI:LO value) predicts every output;
//               directed scenarios pin the model with literal values, then
//               randomized traffic is compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_antares_hilo_unit;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [2:0]  issue_op;
    logic [31:0] mt_data;
    logic [63:0] mult_result;
    logic        mult_ready;
    logic        stall;
    logic        flush;
    logic        mult_enable_op;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] gpr_result;
    logic        gpr_valid;
    logic        hilo_busy;
    logic        err;

    antares_hilo_unit dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_op       (issue_op),
        .mt_data        (mt_data),
        .mult_result    (mult_result),
        .mult_ready     (mult_ready),
        .stall          (stall),
        .flush          (flush),
        .mult_enable_op (mult_enable_op),
        .hi             (hi),
        .lo             (lo),
        .gpr_result     (gpr_result),
        .gpr_valid      (gpr_valid),
        .hilo_busy      (hilo_busy),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [1:0]  mq [$];
    logic [63:0] m_hilo;
    logic [31:0] m_gr;
    logic        m_gv;
    logic        m_err;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_hilo = '0;
        m_gr   = '0;
        m_gv   = 1'b0;
        m_err  = 1'b0;
    endtask

    // One clock edge of architectural behaviour, from the sampled inputs.
    task automatic model_step();
        int          n0;
        logic [63:0] old;
        logic [1:0]  tag;
        bit          popped;
        m_gv = 1'b0;
        if (flush) begin
            mq.delete();
            return;
        end
        if (stall) return;
        n0     = mq.size();
        old    = m_hilo;
        popped = 0;
        tag    = 2'd0;
        if (mult_ready) begin
            if (n0 == 0) m_err = 1'b1;
            else begin
                tag    = mq.pop_front();
                popped = 1;
            end
        end
        if (issue_valid) begin
            if (issue_op <= 3'd3) begin
                if (n0 == 4) m_err = 1'b1;
                else mq.push_back(issue_op[1:0]);
            end else if (issue_op == 3'd4 || issue_op == 3'd5) begin
                if (n0 != 0) m_err = 1'b1;
                if (issue_op == 3'd4) m_hilo[63:32] = mt_data;
                else                  m_hilo[31:0]  = mt_data;
            end else begin
                m_err = 1'b1;
            end
        end
        if (popped) begin
            case (tag)
                2'd0: m_hilo = mult_result;
                2'd1: m_hilo = old + mult_result;
                2'd2: m_hilo = old - mult_result;
                default: begin
                    m_gr = mult_result[31:0];
                    m_gv = 1'b1;
                end
            endcase
        end
    endtask

    task automatic compare_all();
        chk("hi",         {32'd0, hi},         {32'd0, m_hilo[63:32]});
        chk("lo",         {32'd0, lo},         {32'd0, m_hilo[31:0]});
        chk("gpr_result", {32'd0, gpr_result}, {32'd0, m_gr});
        chk("gpr_valid",  {63'd0, gpr_valid},  {63'd0, m_gv});
        chk("hilo_busy",  {63'd0, hilo_busy},  {63'd0, (mq.size() != 0)});
        chk("err",        {63'd0, err},        {63'd0, m_err});
    endtask

    task automatic drv(input logic iv, input logic [2:0] op, input logic [31:0] md,
                       input logic mr, input logic [63:0] res,
                       input logic st, input logic fl);
        issue_valid = iv;
        issue_op    = op;
        mt_data     = md;
        mult_ready  = mr;
        mult_result = res;
        stall       = st;
        flush       = fl;
    endtask

    task automatic idle();
        drv(1'b0, 3'd0, 32'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    // Called at a falling edge with inputs already driven: checks the
    // combinational strobe, advances one clock, checks registered outputs.
    task automatic cyc();
        logic exp_en;
        #1;
        exp_en = issue_valid && (issue_op <= 3'd3) && !stall && !flush;
        chk("mult_enable_op", {63'd0, mult_enable_op}, {63'd0, exp_en});
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Async reset asserted between edges, checked before the next edge.
    task automatic async_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        cyc();
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        cyc();
        cyc();
        chk("rst_hi",   {32'd0, hi},         64'd0);
        chk("rst_lo",   {32'd0, lo},         64'd0);
        chk("rst_gpr",  {32'd0, gpr_result}, 64'd0);
        chk("rst_err",  {63'd0, err},        64'd0);
        chk("rst_busy", {63'd0, hilo_busy},  64'd0);
        rst = 1'b1;

        // MULT 7*6: busy through the flight, lo=42 one cycle after the pop
        drv(1'b1, 3'd0, 32'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        cyc();
        chk("t36_busy_c1", {63'd0, hilo_busy}, 64'd1);
        idle();
        cyc();
        cyc();
        chk("t36_busy_c3", {63'd0, hilo_busy}, 64'd1);
        drv(1'b0, 3'd0, 32'd0, 1'b1, 64'd42, 1'b0, 1'b0);
        chk("t36_busy_c4", {63'd0, hilo_busy}, 64'd1);
        cyc();
        chk("t36_hi",   {32'd0, hi}, 64'd0);
        chk("t36_lo",   {32'd0, lo}, 64'd42);
        chk("t36_busy", {63'd0, hilo_busy}, 64'd0);

        // MULT then MADD
        drv(1'b1, 3'd0, 32'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        cyc();
        drv(1'b1, 3'd1, 32'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        cyc();
        drv(1'b0, 3'd0, 32'd0, 1'b1, 64'h1_0000_0000, 1'b0, 1'b0);
        cyc();
        chk("t37_hi_a", {32'd0, hi}, 64'd1);
        chk("t37_lo_a", {32'd0, lo}, 64'd0);
        drv(1'b0, 3'd0, 32'd0, 1'b1, 64'hFFFF_FFFF, 1'b0, 1'b0);
        cyc();
        chk("t37_hi_b", {32'd0, hi}, 64'd1);
        chk("t37_lo_b", {32'd0, lo}, 64'hFFFF_FFFF);

        // Clear via MTHI/MTLO, then MSUB 1 wraps to all ones
        drv(1'b1, 3'd4, 32'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        cyc();
        drv(1'b1, 3'd5, 32'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        cyc();
        chk("t38_hi0", {32'd0, hi}, 64'd0);
        chk("t38_lo0", {32'd0, lo}, 64'd0);
        drv(1'b1, 3'd2, 32'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        cyc();
        drv(1'b0, 3'd0, 32'd0, 1'b1, 64'd1, 1'b0, 1'b0);
        cyc();
        chk("t38_hi",  {32'd0, hi},  64'hFFFF_FFFF);
        chk("t38_lo",  {32'd0, lo},  64'hFFFF_FFFF);
        chk("t38_err", {63'd0, err}, 64'd0);

        // MUL to GPR
        drv(1'b1, 3'd3, 32'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        cyc();
        drv(1'b0, 3'd0, 32'd0, 1'b1, 64'h0000_0003_8000_0001, 1'b0, 1'b0);
        cyc();
        chk("t39_gpr", {32'd0, gpr_result}, 64'h8000_0001);
        chk("t39_gv",  {63'd0, gpr_valid},  64'd1);
        chk("t39_hi",  {32'd0, hi},         64'hFFFF_FFFF);
        chk("t39_lo",  {32'd0, lo},         64'hFFFF_FFFF);
        idle();
        cyc();
        chk("t39_gv_off", {63'd0, gpr_valid}, 64'd0);

        // Four MULTs with a 3-cycle stall, one pop, then flush at count 3
        drv(1'b1, 3'd0, 32'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        cyc();
        cyc();
        drv(1'b1, 3'd0, 32'd0, 1'b1, 64'd5, 1'b1, 1'b0);
        repeat (3) cyc();
        drv(1'b1, 3'd0, 32'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        cyc();
        cyc();
        drv(1'b0, 3'd0, 32'd0, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
        cyc();
        drv(1'b1, 3'd0, 32'd0, 1'b1, 64'd9, 1'b0, 1'b1);
        cyc();
        chk("t40_busy", {63'd0, hilo_busy}, 64'd0);
        chk("t40_hi",   {32'd0, hi},        64'h1234_5678);
        chk("t40_lo",   {32'd0, lo},        64'h9ABC_DEF0);
        chk("t40_err0", {63'd0, err},       64'd0);
        drv(1'b0, 3'd0, 32'd0, 1'b1, 64'd9, 1'b0, 1'b0);
        cyc();
        chk("t40_err1", {63'd0, err}, 64'd1);

        // Async reset with two products in flight
        idle();
        async_reset();
        drv(1'b1, 3'd0, 32'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        cyc();
        cyc();
        chk("t41_busy_pre", {63'd0, hilo_busy}, 64'd1);
        idle();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("t41_hi",   {32'd0, hi},         64'd0);
        chk("t41_lo",   {32'd0, lo},         64'd0);
        chk("t41_gpr",  {32'd0, gpr_result}, 64'd0);
        chk("t41_gv",   {63'd0, gpr_valid},  64'd0);
        chk("t41_busy", {63'd0, hilo_busy},  64'd0);
        chk("t41_err",  {63'd0, err},        64'd0);
        cyc();
        rst = 1'b1;
        drv(1'b0, 3'd0, 32'd0, 1'b1, 64'd77, 1'b0, 1'b0);
        cyc();
        chk("t41_late_err", {63'd0, err}, 64'd1);

        // Randomized traffic in segments separated by async resets
        for (int seg = 0; seg < 6; seg++) begin
            idle();
            async_reset();
            for (int c = 0; c < 150; c++) begin
                int r;
                logic       iv, mr, st, fl;
                logic [2:0] op;
                iv = ($urandom_range(0, 99) < 50);
                r  = $urandom_range(0, 99);
                if (r < 72)      op = 3'($urandom_range(0, 3));
                else if (r < 97) op = 3'($urandom_range(4, 5));
                else             op = 3'($urandom_range(6, 7));
                if (mq.size() != 0) mr = ($urandom_range(0, 99) < 45);
                else                mr = ($urandom_range(0, 99) < 2);
                st = ($urandom_range(0, 99) < 10);
                fl = ($urandom_range(0, 99) < 3);
                drv(iv, op, $urandom, mr, {$urandom, $urandom}, st, fl);
                cyc();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
